// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the MEM stage: Funct3 access
//               codes, MEM FSM states and the write-back packet.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        regwrite;
    } wb_pkt_t;

    // Unsupported codes fall back to a full-word access.
    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_B;
            F3_H, F3_HU: f3_size = SZ_H;
            default:     f3_size = SZ_W;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module      : load_align
// Description : Combinational load-data lane selection and sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import riscv_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    off,
    input  logic [2:0]    funct3,
    output logic [DW-1:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword offsets are already aligned by the caller, so only off[1] matters.
    assign w_byte = rdata[{off, 3'b000} +: 8];
    assign w_half = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:          result = {{(DW-8){w_byte[7]}}, w_byte};
            F3_BU:         result = {{(DW-8){1'b0}}, w_byte};
            F3_H:          result = {{(DW-16){w_half[15]}}, w_half};
            F3_HU:         result = {{(DW-16){1'b0}}, w_half};
            F3_W:          result = rdata;
            default:       result = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module      : mem_access_stage
// Description : RV32 MEM stage: single-outstanding req/ready data bus, store
//               lane steering, load alignment and write-back packet.
//               Optional macro MEM_MISALIGN_TRAP_EN traps misaligned H/W ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          InValid,
    output logic          InReady,
    input  logic [31:0]   ALUResult,
    input  logic [DW-1:0] StoreData,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [2:0]    Funct3,
    input  logic [4:0]    Rd,
    input  logic          RegWrite,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    output logic [3:0]    MemWStrb,
    input  logic          MemReady,
    input  logic [DW-1:0] MemRData,
    output logic          WbValid,
    output logic [31:0]   WbData,
    output logic [4:0]    WbRd,
    output logic          WbRegWrite
`ifdef MEM_MISALIGN_TRAP_EN
   ,output logic          MisalignErr
`endif
);

    mem_state_t    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_wstrb_q, mem_wstrb_d;
    logic          wb_valid_q, wb_valid_d;
    wb_pkt_t       wb_q, wb_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    f3_q, f3_d;
    logic          load_q, load_d;
    logic [4:0]    rd_q, rd_d;
    logic          regwrite_q, regwrite_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic          misalign_q, misalign_d;
    logic          w_misaligned;
`endif

    logic          w_accept;
    logic          w_is_mem;
    logic [1:0]    w_size;
    logic [1:0]    w_raw_off;
    logic [1:0]    w_eff_off;
    logic [3:0]    w_strb;
    logic [DW-1:0] w_store_wdata;
    logic [DW-1:0] w_load_result;

    assign w_accept  = InValid && (state_q == IDLE);
    assign w_is_mem  = MemRead || MemWrite;
    assign w_size    = f3_size(Funct3);
    assign w_raw_off = ALUResult[1:0];

    // Halfword and word accesses ignore the offset bits they cannot use.
    always_comb begin
        w_eff_off     = 2'b00;
        w_strb        = 4'b1111;
        w_store_wdata = StoreData;
        case (w_size)
            SZ_B: begin
                w_eff_off     = w_raw_off;
                w_strb        = 4'b0001 << w_raw_off;
                w_store_wdata = {4{StoreData[7:0]}};
            end
            SZ_H: begin
                w_eff_off     = {w_raw_off[1], 1'b0};
                w_strb        = 4'b0011 << {w_raw_off[1], 1'b0};
                w_store_wdata = {2{StoreData[15:0]}};
            end
            default: begin
                w_eff_off     = 2'b00;
                w_strb        = 4'b1111;
                w_store_wdata = StoreData;
            end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misaligned = ((w_size == SZ_H) && w_raw_off[0]) ||
                          ((w_size == SZ_W) && (w_raw_off != 2'b00));
`endif

    load_align #(.DW(DW)) u_load_align (
        .rdata  (MemRData),
        .off    (off_q),
        .funct3 (f3_q),
        .result (w_load_result)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        wb_valid_d  = 1'b0;
        wb_d        = wb_q;
        off_d       = off_q;
        f3_d        = f3_q;
        load_d      = load_q;
        rd_d        = rd_q;
        regwrite_d  = regwrite_q;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (!w_is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_d       = '{data: ALUResult, rd: Rd,
                                       regwrite: RegWrite && (Rd != 5'd0)};
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    else if (w_misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_d       = '{data: ALUResult, rd: Rd, regwrite: 1'b0};
                        misalign_d = 1'b1;
                    end
`endif
                    else begin
                        state_d     = BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = MemWrite;
                        mem_addr_d  = {ALUResult[AW-1:2], 2'b00};
                        mem_wdata_d = w_store_wdata;
                        mem_wstrb_d = MemWrite ? w_strb : 4'b0000;
                        off_d       = w_eff_off;
                        f3_d        = Funct3;
                        load_d      = !MemWrite;
                        rd_d        = Rd;
                        regwrite_d  = RegWrite;
                    end
                end
            end
            BUSY: begin
                if (MemReady) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_d       = '{data: load_q ? w_load_result : '0, rd: rd_q,
                                   regwrite: load_q && regwrite_q && (rd_q != 5'd0)};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            wb_valid_q  <= 1'b0;
            wb_q        <= '0;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
            load_q      <= 1'b0;
            rd_q        <= 5'd0;
            regwrite_q  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            wb_valid_q  <= wb_valid_d;
            wb_q        <= wb_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            load_q      <= load_d;
            rd_q        <= rd_d;
            regwrite_q  <= regwrite_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign InReady    = (state_q == IDLE);
    assign MemReq     = mem_req_q;
    assign MemWe      = mem_we_q;
    assign MemAddr    = mem_addr_q;
    assign MemWData   = mem_wdata_q;
    assign MemWStrb   = mem_wstrb_q;
    assign WbValid    = wb_valid_q;
    assign WbData     = wb_q.data;
    assign WbRd       = wb_q.rd;
    assign WbRegWrite = wb_q.regwrite;
`ifdef MEM_MISALIGN_TRAP_EN
    assign MisalignErr = misalign_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage: directed scenarios
//               plus randomized traffic against a transaction-level model.
//               Honours MEM_MISALIGN_TRAP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] ALUResult = '0;
    logic [31:0] StoreData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [4:0]  Rd = 5'd0;
    logic        RegWrite = 1'b0;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemWStrb;
    logic        MemReady = 1'b0;
    logic [31:0] MemRData = '0;
    logic        WbValid;
    logic [31:0] WbData;
    logic [4:0]  WbRd;
    logic        WbRegWrite;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        MisalignErr;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .InValid    (InValid),
        .InReady    (InReady),
        .ALUResult  (ALUResult),
        .StoreData  (StoreData),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .Rd         (Rd),
        .RegWrite   (RegWrite),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemWStrb   (MemWStrb),
        .MemReady   (MemReady),
        .MemRData   (MemRData),
        .WbValid    (WbValid),
        .WbData     (WbData),
        .WbRd       (WbRd),
        .WbRegWrite (WbRegWrite)
`ifdef MEM_MISALIGN_TRAP_EN
       ,.MisalignErr(MisalignErr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Transaction-level model: what the bus and write-back port must show.
    typedef struct {
        bit          busy;
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          wbv;
        logic [31:0] wbd;
        logic [4:0]  wbrd;
        bit          wbrw;
        bit          chkd;
        bit          mis;
        bit          p_load;
        int          p_off;
        int          p_size;
        bit          p_sgn;
        logic [4:0]  p_rd;
        bit          p_rw;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t z;
        z.busy = 0; z.req = 0; z.we = 0; z.addr = '0; z.wdata = '0; z.strb = '0;
        z.wbv = 0; z.wbd = '0; z.wbrd = '0; z.wbrw = 0; z.chkd = 0; z.mis = 0;
        z.p_load = 0; z.p_off = 0; z.p_size = 4; z.p_sgn = 0; z.p_rd = '0; z.p_rw = 0;
        return z;
    endfunction

    function automatic model_t model_step(input model_t cur);
        model_t      n;
        int          size;
        int          off;
        int          eoff;
        logic [31:0] sh;
        logic [31:0] v;
        n = cur;
        n.wbv = 0; n.mis = 0; n.chkd = 0;
        if (!cur.busy) begin
            if (InValid) begin
                size = (Funct3[1:0] == 2'b00) ? 1 : (Funct3[1:0] == 2'b01) ? 2 : 4;
                off  = int'(ALUResult[1:0]);
                if (!(MemRead || MemWrite)) begin
                    n.wbv = 1; n.wbd = ALUResult; n.wbrd = Rd;
                    n.wbrw = RegWrite && (Rd != 5'd0); n.chkd = 1;
                end
`ifdef MEM_MISALIGN_TRAP_EN
                else if ((off % size) != 0) begin
                    n.wbv = 1; n.wbrd = Rd; n.wbrw = 0; n.mis = 1;
                end
`endif
                else begin
                    eoff   = off - (off % size);
                    n.busy = 1; n.req = 1; n.we = MemWrite;
                    n.addr = ALUResult & 32'hFFFF_FFFC;
                    if (size == 1)      n.wdata = {4{StoreData[7:0]}};
                    else if (size == 2) n.wdata = {2{StoreData[15:0]}};
                    else                n.wdata = StoreData;
                    n.strb = MemWrite ? 4'(((1 << size) - 1) << eoff) : 4'b0000;
                    n.p_load = !MemWrite; n.p_off = eoff; n.p_size = size;
                    n.p_sgn = !Funct3[2]; n.p_rd = Rd; n.p_rw = RegWrite;
                end
            end
        end else if (MemReady) begin
            n.busy = 0; n.req = 0; n.wbv = 1; n.wbrd = cur.p_rd;
            n.wbrw = cur.p_load && cur.p_rw && (cur.p_rd != 5'd0);
            n.chkd = cur.p_load;
            sh = MemRData >> (8 * cur.p_off);
            if (cur.p_size == 1) begin
                v = sh & 32'h0000_00FF;
                if (cur.p_sgn && v[7]) v = v | 32'hFFFF_FF00;
            end else if (cur.p_size == 2) begin
                v = sh & 32'h0000_FFFF;
                if (cur.p_sgn && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = MemRData;
            end
            n.wbd = v;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m);
    end

    always @(negedge clk) begin
        chk("InReady", 32'(InReady), 32'(!m.busy));
        chk("MemReq", 32'(MemReq), 32'(m.req));
        chk("WbValid", 32'(WbValid), 32'(m.wbv));
        if (m.req) begin
            chk("MemWe", 32'(MemWe), 32'(m.we));
            chk("MemAddr", MemAddr, m.addr);
            chk("MemWStrb", 32'(MemWStrb), 32'(m.strb));
            if (m.we) chk("MemWData", MemWData, m.wdata);
        end
        if (m.wbv) begin
            chk("WbRd", 32'(WbRd), 32'(m.wbrd));
            chk("WbRegWrite", 32'(WbRegWrite), 32'(m.wbrw));
            if (m.chkd) chk("WbData", WbData, m.wbd);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        chk("MisalignErr", 32'(MisalignErr), 32'(m.mis));
`endif
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] sd, input logic mr,
                         input logic mw, input logic [2:0] f3, input logic [4:0] rd,
                         input logic rw);
        InValid = 1'b1; ALUResult = a; StoreData = sd; MemRead = mr; MemWrite = mw;
        Funct3 = f3; Rd = rd; RegWrite = rw;
    endtask

    initial begin
        #1;
        chk("reset_InReady", 32'(InReady), 32'd1);
        chk("reset_MemReq", 32'(MemReq), 32'd0);
        chk("reset_WbValid", 32'(WbValid), 32'd0);
        chk("reset_MemAddr", MemAddr, 32'd0);
        #21 rst = 1'b0;

        // Non-memory op passes ALUResult straight through in one cycle.
        @(posedge clk); #1;
        drive(32'h0000_1234, 32'h0, 1'b0, 1'b0, F3_W, 5'd5, 1'b1);
        @(posedge clk); #1 InValid = 1'b0;
        @(negedge clk);
        chk("alu_WbValid", 32'(WbValid), 32'd1);
        chk("alu_WbData", WbData, 32'h0000_1234);
        chk("alu_WbRd", 32'(WbRd), 32'd5);
        chk("alu_WbRegWrite", 32'(WbRegWrite), 32'd1);

        // LB then LBU at 0x103, zero wait states.
        MemReady = 1'b1; MemRData = 32'h80AA_BBCC;
        @(posedge clk); #1;
        drive(32'h0000_0103, 32'h0, 1'b1, 1'b0, F3_B, 5'd7, 1'b1);
        @(posedge clk); #1 InValid = 1'b0;
        @(negedge clk);
        chk("lb_MemReq", 32'(MemReq), 32'd1);
        chk("lb_MemAddr", MemAddr, 32'h0000_0100);
        chk("lb_MemWStrb", 32'(MemWStrb), 32'd0);
        @(negedge clk);
        chk("lb_WbValid", 32'(WbValid), 32'd1);
        chk("lb_WbData", WbData, 32'hFFFF_FF80);
        @(posedge clk); #1;
        drive(32'h0000_0103, 32'h0, 1'b1, 1'b0, F3_BU, 5'd7, 1'b1);
        @(posedge clk); #1 InValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lbu_WbData", WbData, 32'h0000_0080);

        // SH at 0x202 with three wait states.
        @(posedge clk); #1;
        MemReady = 1'b0;
        drive(32'h0000_0202, 32'h1234_ABCD, 1'b0, 1'b1, F3_H, 5'd3, 1'b1);
        @(posedge clk); #1 InValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sh_InReady", 32'(InReady), 32'd0);
            chk("sh_MemReq", 32'(MemReq), 32'd1);
            chk("sh_MemWStrb", 32'(MemWStrb), 32'b1100);
            chk("sh_MemWData", MemWData, 32'hABCD_ABCD);
            chk("sh_MemAddr", MemAddr, 32'h0000_0200);
        end
        @(posedge clk); #1 MemReady = 1'b1;
        @(posedge clk); #1 MemReady = 1'b0;
        @(negedge clk);
        chk("sh_WbValid", 32'(WbValid), 32'd1);
        chk("sh_WbRegWrite", 32'(WbRegWrite), 32'd0);

        // LW to x0 never writes back.
        MemReady = 1'b1; MemRData = 32'hCAFE_F00D;
        @(posedge clk); #1;
        drive(32'h0000_0500, 32'h0, 1'b1, 1'b0, F3_W, 5'd0, 1'b1);
        @(posedge clk); #1 InValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lwx0_WbValid", 32'(WbValid), 32'd1);
        chk("lwx0_WbRegWrite", 32'(WbRegWrite), 32'd0);

        // Reset while BUSY drops the request at once and discards the access.
        MemReady = 1'b0;
        @(posedge clk); #1;
        drive(32'h0000_0400, 32'h0, 1'b1, 1'b0, F3_W, 5'd9, 1'b1);
        @(posedge clk); #1 InValid = 1'b0;
        @(negedge clk);
        chk("rst_pre_MemReq", 32'(MemReq), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_MemReq", 32'(MemReq), 32'd0);
        chk("rst_InReady", 32'(InReady), 32'd1);
        @(negedge clk); #2 rst = 1'b0; MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_WbValid", 32'(WbValid), 32'd0);
        end

        // Misaligned LW at 0x301.
        MemReady = 1'b1; MemRData = 32'h89AB_CDEF;
        @(posedge clk); #1;
        drive(32'h0000_0301, 32'h0, 1'b1, 1'b0, F3_W, 5'd4, 1'b1);
        @(posedge clk); #1 InValid = 1'b0;
        @(negedge clk);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_MemReq", 32'(MemReq), 32'd0);
        chk("mis_Err", 32'(MisalignErr), 32'd1);
        chk("mis_WbValid", 32'(WbValid), 32'd1);
        chk("mis_WbRegWrite", 32'(WbRegWrite), 32'd0);
        @(negedge clk);
        chk("mis_MemReq2", 32'(MemReq), 32'd0);
        chk("mis_Err2", 32'(MisalignErr), 32'd0);
`else
        chk("mis_MemReq", 32'(MemReq), 32'd1);
        chk("mis_MemAddr", MemAddr, 32'h0000_0300);
        @(negedge clk);
        chk("mis_WbValid", 32'(WbValid), 32'd1);
        chk("mis_WbData", WbData, 32'h89AB_CDEF);
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ((i % 700) == 350) begin
                @(negedge clk); #2 rst = 1'b1; #2 rst = 1'b0;
            end
            @(posedge clk); #1;
            InValid   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       begin MemRead = 1'b0; MemWrite = 1'b0; end
                1:       begin MemRead = 1'b1; MemWrite = 1'b0; end
                2:       begin MemRead = 1'b0; MemWrite = 1'b1; end
                default: begin MemRead = 1'b1; MemWrite = 1'b1; end
            endcase
            ALUResult = $urandom;
            StoreData = $urandom;
            Funct3    = 3'($urandom_range(0, 7));
            Rd        = 5'($urandom);
            RegWrite  = 1'($urandom);
            MemReady  = ($urandom_range(0, 2) != 0);
            MemRData  = $urandom;
        end
        InValid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage placed directly downstream of the ALU. It registers the ALU result, store data and control bits from EX, drives a single-outstanding request/ready data-memory bus for loads and stores, aligns and sign/zero-extends load data, and hands a write-back packet to the WB stage. It stalls EX through a ready handshake while a memory access is outstanding.

## Interface
Parameters:
- AW, 32, address width; only bits [AW-1:0] of ALUResult drive the bus.
- DW, 32, data width; fixed at 32 for RV32, with 4 byte lanes.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- InValid  input  1  EX holds a valid instruction.
- InReady  output  1  the stage can accept an instruction; equals (state == IDLE).
- ALUResult  input  32  effective address for memory ops, or the result for other ops.
- StoreData  input  32  rs2 value.
- MemRead, MemWrite  input  1 each  load or store; both high is treated as a store.
- Funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Rd  input  5  destination register.
- RegWrite  input  1  instruction writes Rd.
- MemReq  output  1  bus request.
- MemWe  output  1  1 = store.
- MemAddr  output  32  word-aligned address: {ALUResult[31:2], 2'b00}.
- MemWData  output  32  store data, replicated across the byte lanes.
- MemWStrb  output  4  byte-lane enables (0000 on loads).
- MemReady  input  1  bus accepts or completes the access in this cycle; MemRData is valid in the same cycle.
- MemRData  input  32  read data.
- WbValid  output  1  write-back packet is valid for one cycle.
- WbData  output  32  load result or passed-through ALUResult.
- WbRd  output  5  destination register.
- WbRegWrite  output  1  write enable; forced to 0 when WbRd == 0.
- MisalignErr  output  1  one-cycle pulse; present only when the macro below is defined.

## Operation
- The FSM has two states: IDLE and BUSY. An instruction is accepted when InValid and InReady are both high on a clock edge.
- Accepting a non-memory op:
  - The next cycle has WbValid=1, WbData=ALUResult and WbRd/WbRegWrite from the inputs.
  - The FSM stays in IDLE.
- Accepting a memory op:
  - Register the address, data, Funct3, Rd and RegWrite.
  - Move to BUSY.
- In BUSY:
  - MemReq=1, and the bus outputs are held stable until MemReady.
  - On a cycle with MemReq and MemReady both high, capture MemRData.
  - At that clock edge, return to IDLE and produce WbValid=1 on the next cycle.
- Store lanes (little-endian, off = ALUResult[1:0]):
  - SB: MemWStrb = 1<<off, MemWData = {4{rs2[7:0]}}.
  - SH: MemWStrb = 0011<<off, MemWData = {2{rs2[15:0]}}.
  - SW: MemWStrb = 1111, MemWData = rs2.
- Load extraction:
  - Byte = MemRData >> (8*off); halfword = MemRData >> (8*off).
  - B/H results are sign-extended; BU/HU results are zero-extended.
  - Unsupported Funct3 values (011, 110, 111) behave as W.
- Stores complete with WbValid=1 and WbRegWrite=0.
- If no instruction is accepted in a cycle, WbValid=0 in the following cycle.

## Timing
- Reset values: state=IDLE; MemReq=0, MemWe=0, MemAddr=0, MemWData=0, MemWStrb=0; WbValid=0, WbData=0, WbRd=0, WbRegWrite=0; MisalignErr=0. InReady is therefore 1.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op: acceptance at edge N, MemReq high from cycle N+1, MemReady high at cycle N+1+k, WbValid high in cycle N+2+k.
  - With zero wait states, the next instruction is accepted at edge N+2.
- All outputs are registered except InReady, which decodes the state register.
- MemReq never drops before MemReady is seen, except under reset.
- A MemReady that arrives while MemReq=0 is ignored.
- Reset asserted mid-access drops MemReq immediately (asynchronously). The pending access is discarded and no WbValid is produced.
- Back-to-back non-memory ops sustain one instruction per cycle.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A halfword access with off[0]=1, or a word access with off != 0, issues no bus request.
  - MisalignErr pulses for one cycle with WbValid=1 and WbRegWrite=0, one cycle after acceptance.
  - The FSM stays in IDLE.
- MEM_MISALIGN_TRAP_EN undefined:
  - Offset bits are forced to halfword or word alignment, i.e. the access is performed as if the low bits were zero.
  - The MisalignErr port does not exist.

## Structure
- Shared package riscv_pkg holds:
  - Funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The mem_state_t enum {IDLE, BUSY}.
  - A wb_pkt_t struct (data, rd, regwrite).
- Sub-module load_align: purely combinational. Takes MemRData, off and Funct3 and returns the extended 32-bit result. It is instantiated once.

## Test plan
- Non-memory op with ALUResult=0x0000_1234, Rd=5, RegWrite=1 -> next cycle WbValid=1, WbData=0x0000_1234, WbRd=5, WbRegWrite=1.
- LB at address 0x103 with MemRData=0x80AA_BBCC and zero wait states -> MemAddr=0x100, MemWStrb=0000, WbData=0xFFFF_FF80 two cycles after acceptance; LBU of the same access -> WbData=0x0000_0080.
- SH at address 0x202 with rs2=0x1234_ABCD and MemReady delayed 3 cycles -> MemWStrb=1100, MemWData=0xABCD_ABCD; InReady=0 and the bus outputs are stable throughout; WbValid=1 with WbRegWrite=0 after completion.
- LW with Rd=0 -> WbRegWrite=0 regardless of the RegWrite input.
- rst asserted while in BUSY with MemReady=0 -> MemReq=0 immediately, InReady=1, and no WbValid follows.
- With MEM_MISALIGN_TRAP_EN defined, LW at 0x301 -> MemReq never asserts and MisalignErr=1 one cycle later; with the macro undefined, the same load gives MemAddr=0x300 and WbData=MemRData.
